// File: rtl/sw_pkg.sv
// Shared switch definitions: flit type encodings, arbiter FSM states and the
// `ASSERT/`NEGATE control-level macros.
`ifndef SW_PKG_MACROS
`define SW_PKG_MACROS
`define ASSERT 1'b1
`define NEGATE 1'b0
`endif

package sw_pkg;

    localparam int NUM_PORTS = 4;

    // Flit type lives in the two MSBs of every flit.
    typedef enum logic [1:0] {
        FT_BODY   = 2'b00,
        FT_TAIL   = 2'b01,
        FT_HEAD   = 2'b10,
        FT_SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic is_pkt_start(input logic [1:0] ftype);
        return (ftype == FT_HEAD) || (ftype == FT_SINGLE);
    endfunction

    function automatic logic is_pkt_end(input logic [1:0] ftype);
        return (ftype == FT_TAIL) || (ftype == FT_SINGLE);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way round-robin picker: searches upward from ptr (mod 4)
// and returns a one-hot grant plus an any-request flag.
module rr_pick
    import sw_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 any
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                gnt[idx] = `ASSERT;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pkt_rr_arb.sv
// 4-port packet round-robin arbiter: a grant is held from HEAD to TAIL.
// Optional idle-grant release is enabled by defining ARB_TIMEOUT_EN.
module pkt_rr_arb
    import sw_pkg::*;
#(
    parameter int FLIT_W  = 10,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        in_valid,
    input  logic [FLIT_W-1:0] in_flit0,
    input  logic [FLIT_W-1:0] in_flit1,
    input  logic [FLIT_W-1:0] in_flit2,
    input  logic [FLIT_W-1:0] in_flit3,
    output logic [3:0]        in_ready,
    output logic              out_valid,
    output logic [FLIT_W-1:0] out_flit,
    input  logic              out_ready,
    output logic [3:0]        grant,
    output logic              timeout_pulse
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("pkt_rr_arb: TIMEOUT must be >= 1");
    end
    if (FLIT_W < 3) begin : g_bad_flit_w
        $error("pkt_rr_arb: FLIT_W must leave room for type and payload");
    end

    arb_state_e             state_q, state_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [NUM_PORTS-1:0]   grant_q, grant_d;
    logic                   tpulse_q, tpulse_d;

    logic [NUM_PORTS-1:0][FLIT_W-1:0] flits;
    logic [NUM_PORTS-1:0]   start_req;
    logic [NUM_PORTS-1:0]   pick_gnt;
    logic                   pick_any;
    logic [FLIT_W-1:0]      sel_flit;
    logic                   sel_valid;
    logic [1:0]             sel_idx;
    logic                   locked;
    logic                   xfer;
    logic                   tail_xfer;
    logic                   timeout_hit;

    assign flits[0] = in_flit0;
    assign flits[1] = in_flit1;
    assign flits[2] = in_flit2;
    assign flits[3] = in_flit3;

    // Only packet-opening flits compete; stray BODY/TAIL wait untouched.
    always_comb begin
        start_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            start_req[i] = in_valid[i] & is_pkt_start(flits[i][FLIT_W-1 -: 2]);
        end
    end

    rr_pick u_rr_pick (
        .req (start_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // One-hot AND-OR mux; grant_q is all-zero while idle.
    always_comb begin
        sel_flit  = '0;
        sel_valid = 1'b0;
        sel_idx   = 2'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q[i]) begin
                sel_flit  = sel_flit | flits[i];
                sel_valid = sel_valid | in_valid[i];
                sel_idx   = 2'(i);
            end
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign out_valid = locked & sel_valid;
    assign out_flit  = sel_flit;
    assign xfer      = out_valid & out_ready;
    assign tail_xfer = xfer & is_pkt_end(sel_flit[FLIT_W-1 -: 2]);
    assign grant     = grant_q;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_ready[i] = (locked && grant_q[i] && out_ready) ? `ASSERT : `NEGATE;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counts consecutive LOCKED cycles without a transfer.
    always_comb begin
        cnt_d       = '0;
        timeout_hit = `NEGATE;
        if (locked && !xfer) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                timeout_hit = `ASSERT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = `NEGATE;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        tpulse_d = `NEGATE;
        case (state_q)
            ST_IDLE: begin
                if (pick_any && |pick_gnt) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_gnt;
                end
            end
            ST_LOCKED: begin
                if (tail_xfer || timeout_hit) begin
                    state_d  = ST_IDLE;
                    grant_d  = '0;
                    ptr_d    = sel_idx + 2'd1;
                    tpulse_d = timeout_hit;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            grant_q  <= '0;
            tpulse_q <= `NEGATE;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Directed self-checking bench for pkt_rr_arb (TIMEOUT=4; the timeout test
// follows whether ARB_TIMEOUT_EN is defined).
module tb_pkt_rr_arb;
    import sw_pkg::*;

    localparam int FW = 10;

    logic          clk;
    logic          rst;
    logic [3:0]    in_valid;
    logic [FW-1:0] fl [4];
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [FW-1:0] out_flit;
    logic          out_ready;
    logic [3:0]    grant;
    logic          timeout_pulse;

    int errs   = 0;
    int checks = 0;

    pkt_rr_arb #(.FLIT_W(FW), .TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_flit0      (fl[0]),
        .in_flit1      (fl[1]),
        .in_flit2      (fl[2]),
        .in_flit3      (fl[3]),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_flit      (out_flit),
        .out_ready     (out_ready),
        .grant         (grant),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [7:0] pl);
        return {t, pl};
    endfunction

    // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fl[i] = '0;
        cyc();
        cyc();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fl[i] = mk(FT_HEAD, 8'(i));
        cyc();
        mid();
        if (grant !== 4'b0000) begin errs++; $display("FAIL rst_grant got=%b exp=0000", grant); end
        checks++;
        if (in_ready !== 4'b0000) begin errs++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (timeout_pulse !== 1'b0) begin errs++; $display("FAIL rst_tpulse got=%b exp=0", timeout_pulse); end
        checks++;
    endtask

    task automatic test_single_port_packet();
        do_reset();
        in_valid = 4'b0100;
        fl[2]    = mk(FT_HEAD, 8'h21);
        mid();
        if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            errs++; $display("FAIL sp_idle grant=%b valid=%b exp 0000/0", grant, out_valid);
        end
        checks++;
        cyc();
        mid();
        if (grant !== 4'b0100 || in_ready !== 4'b0100) begin
            errs++; $display("FAIL sp_grant grant=%b ready=%b exp 0100/0100", grant, in_ready);
        end
        checks++;
        if (out_valid !== 1'b1 || out_flit !== mk(FT_HEAD, 8'h21)) begin
            errs++; $display("FAIL sp_head valid=%b flit=%h exp 1/%h", out_valid, out_flit, mk(FT_HEAD, 8'h21));
        end
        checks++;
        cyc();
        fl[2] = mk(FT_BODY, 8'h22);
        mid();
        if (grant !== 4'b0100 || out_flit !== mk(FT_BODY, 8'h22)) begin
            errs++; $display("FAIL sp_body grant=%b flit=%h exp 0100/%h", grant, out_flit, mk(FT_BODY, 8'h22));
        end
        checks++;
        cyc();
        fl[2] = mk(FT_TAIL, 8'h23);
        mid();
        if (out_valid !== 1'b1 || out_flit !== mk(FT_TAIL, 8'h23)) begin
            errs++; $display("FAIL sp_tail valid=%b flit=%h exp 1/%h", out_valid, out_flit, mk(FT_TAIL, 8'h23));
        end
        checks++;
        cyc();
        in_valid = 4'b1001;
        fl[0]    = mk(FT_HEAD, 8'h01);
        fl[3]    = mk(FT_HEAD, 8'h31);
        mid();
        if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            errs++; $display("FAIL sp_release grant=%b valid=%b exp 0000/0", grant, out_valid);
        end
        checks++;
        cyc();
        mid();
        if (grant !== 4'b1000) begin errs++; $display("FAIL sp_ptr3 grant=%b exp=1000", grant); end
        checks++;
    endtask

    task automatic test_all_ports();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 4; i++) fl[i] = mk(FT_HEAD, 8'(8'h40 + i));
        in_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int p;
            p = order[n];
            mid();
            if (grant !== 4'b0000) begin errs++; $display("FAIL all_gap%0d grant=%b exp=0000", n, grant); end
            checks++;
            cyc();
            mid();
            if (grant !== 4'(1 << p) || out_flit !== mk(FT_HEAD, 8'(8'h40 + p))) begin
                errs++; $display("FAIL all_head%0d grant=%b flit=%h exp %b/%h", n, grant, out_flit,
                                 4'(1 << p), mk(FT_HEAD, 8'(8'h40 + p)));
            end
            checks++;
            cyc();
            fl[p] = mk(FT_TAIL, 8'(8'h50 + p));
            mid();
            if (grant !== 4'(1 << p) || out_flit !== mk(FT_TAIL, 8'(8'h50 + p))) begin
                errs++; $display("FAIL all_tail%0d grant=%b flit=%h exp %b/%h", n, grant, out_flit,
                                 4'(1 << p), mk(FT_TAIL, 8'(8'h50 + p)));
            end
            checks++;
            cyc();
            fl[p] = mk(FT_HEAD, 8'(8'h40 + p));
        end
    endtask

    task automatic test_no_preempt();
        do_reset();
        in_valid = 4'b0010;
        fl[1]    = mk(FT_HEAD, 8'h11);
        cyc();
        mid();
        if (grant !== 4'b0010 || out_flit !== mk(FT_HEAD, 8'h11)) begin
            errs++; $display("FAIL np_head grant=%b flit=%h exp 0010/%h", grant, out_flit, mk(FT_HEAD, 8'h11));
        end
        checks++;
        cyc();
        fl[1]     = mk(FT_BODY, 8'h12);
        fl[0]     = mk(FT_HEAD, 8'h01);
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        mid();
        if (in_ready !== 4'b0000 || out_valid !== 1'b1 || grant !== 4'b0010) begin
            errs++; $display("FAIL np_stall ready=%b valid=%b grant=%b exp 0000/1/0010", in_ready, out_valid, grant);
        end
        checks++;
        cyc();
        out_ready = 1'b1;
        mid();
        if (in_ready !== 4'b0010 || out_flit !== mk(FT_BODY, 8'h12)) begin
            errs++; $display("FAIL np_body ready=%b flit=%h exp 0010/%h", in_ready, out_flit, mk(FT_BODY, 8'h12));
        end
        checks++;
        cyc();
        fl[1] = mk(FT_TAIL, 8'h13);
        mid();
        if (in_ready !== 4'b0010 || out_flit !== mk(FT_TAIL, 8'h13)) begin
            errs++; $display("FAIL np_tail ready=%b flit=%h exp 0010/%h", in_ready, out_flit, mk(FT_TAIL, 8'h13));
        end
        checks++;
        cyc();
        in_valid = 4'b0001;
        mid();
        if (grant !== 4'b0000) begin errs++; $display("FAIL np_gap grant=%b exp=0000", grant); end
        checks++;
        cyc();
        mid();
        if (grant !== 4'b0001 || out_flit !== mk(FT_HEAD, 8'h01)) begin
            errs++; $display("FAIL np_port0 grant=%b flit=%h exp 0001/%h", grant, out_flit, mk(FT_HEAD, 8'h01));
        end
        checks++;
    endtask

    task automatic test_single_wrap();
        do_reset();
        in_valid = 4'b1000;
        fl[3]    = mk(FT_SINGLE, 8'h3a);
        cyc();
        mid();
        if (grant !== 4'b1000 || in_ready !== 4'b1000 || out_flit !== mk(FT_SINGLE, 8'h3a)) begin
            errs++; $display("FAIL sg_xfer grant=%b ready=%b flit=%h exp 1000/1000/%h", grant, in_ready,
                             out_flit, mk(FT_SINGLE, 8'h3a));
        end
        checks++;
        cyc();
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) fl[i] = mk(FT_HEAD, 8'(8'h60 + i));
        mid();
        if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            errs++; $display("FAIL sg_release grant=%b valid=%b exp 0000/0", grant, out_valid);
        end
        checks++;
        cyc();
        mid();
        if (grant !== 4'b0001) begin errs++; $display("FAIL sg_ptr_wrap grant=%b exp=0001", grant); end
        checks++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        in_valid = 4'b0100;
        fl[2]    = mk(FT_SINGLE, 8'h20);
        cyc();
        cyc();
        fl[2] = mk(FT_HEAD, 8'h24);
        cyc();
        cyc();
        fl[2] = mk(FT_BODY, 8'h25);
        mid();
        if (grant !== 4'b0100 || out_flit !== mk(FT_BODY, 8'h25)) begin
            errs++; $display("FAIL rm_body grant=%b flit=%h exp 0100/%h", grant, out_flit, mk(FT_BODY, 8'h25));
        end
        checks++;
        #2;
        rst = 1'b0;
        #1;
        if (grant !== 4'b0000 || in_ready !== 4'b0000 || out_valid !== 1'b0) begin
            errs++; $display("FAIL rm_async grant=%b ready=%b valid=%b exp 0000/0000/0", grant, in_ready, out_valid);
        end
        checks++;
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        mid();
        if (grant !== 4'b0000 || out_valid !== 1'b0) begin
            errs++; $display("FAIL rm_body_ignored grant=%b valid=%b exp 0000/0", grant, out_valid);
        end
        checks++;
        in_valid = 4'b1100;
        fl[2]    = mk(FT_HEAD, 8'h26);
        fl[3]    = mk(FT_HEAD, 8'h36);
        cyc();
        mid();
        if (grant !== 4'b0100) begin errs++; $display("FAIL rm_ptr0 grant=%b exp=0100", grant); end
        checks++;
    endtask

    task automatic test_timeout();
        do_reset();
        in_valid = 4'b0010;
        fl[1]    = mk(FT_HEAD, 8'h17);
        cyc();
        cyc();
        in_valid = 4'b0000;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            mid();
            if (grant !== 4'b0010 || timeout_pulse !== 1'b0) begin
                errs++; $display("FAIL to_hold%0d grant=%b pulse=%b exp 0010/0", k, grant, timeout_pulse);
            end
            checks++;
            cyc();
        end
        mid();
        if (timeout_pulse !== 1'b1 || grant !== 4'b0000) begin
            errs++; $display("FAIL to_fire pulse=%b grant=%b exp 1/0000", timeout_pulse, grant);
        end
        checks++;
        cyc();
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) fl[i] = mk(FT_HEAD, 8'(8'h70 + i));
        mid();
        if (timeout_pulse !== 1'b0) begin errs++; $display("FAIL to_one_cycle pulse=%b exp=0", timeout_pulse); end
        checks++;
        cyc();
        mid();
        if (grant !== 4'b0100) begin errs++; $display("FAIL to_ptr2 grant=%b exp=0100", grant); end
        checks++;
`else
        for (int k = 0; k < 10; k++) begin
            mid();
            if (grant !== 4'b0010 || timeout_pulse !== 1'b0) begin
                errs++; $display("FAIL to_held%0d grant=%b pulse=%b exp 0010/0", k, grant, timeout_pulse);
            end
            checks++;
            cyc();
        end
`endif
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fl[i] = '0;
        #1;
        test_reset();
        test_single_port_packet();
        test_all_ports();
        test_no_preempt();
        test_single_wrap();
        test_reset_mid_packet();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
